// File: rtl/mem_vout_ring_reader_if.sv
// DDR read-port bundle between the video-out ring reader (master) and the DDR read port (slave).
interface mem_vout_ring_reader_if #(
   parameter int unsigned ADDR_WIDTH    = 30,
   parameter int unsigned MEM_DATA_BITS = 256
);
   logic                     rd_ddr_req;
   logic [7:0]               rd_ddr_len;
   logic [ADDR_WIDTH-1:0]    rd_ddr_addr;
   logic                     rd_ddr_data_valid;
   logic [MEM_DATA_BITS-1:0] rd_ddr_data;
   logic                     rd_ddr_finish;

   modport master (
      output rd_ddr_req, rd_ddr_len, rd_ddr_addr,
      input  rd_ddr_data_valid, rd_ddr_data, rd_ddr_finish
   );

   modport slave (
      input  rd_ddr_req, rd_ddr_len, rd_ddr_addr,
      output rd_ddr_data_valid, rd_ddr_data, rd_ddr_finish
   );
endinterface

// File: rtl/mem_vout_ring_reader.sv
// Video-out DDR ring reader: paces line bursts from a wrap-around DDR region against the
// writer's line count and buffers beats in an internal width-converting FIFO (low word first).
// Optional burst watchdog enabled by defining MEM_VOUT_TIMEOUT_EN.
module mem_vout_ring_reader #(
   parameter int unsigned MEM_SEL_BIT   = 1,
   parameter int unsigned ADDR_WIDTH    = 30,
   parameter int unsigned MEM_DATA_BITS = 256,
   parameter int unsigned OUT_WIDTH     = 64,
   parameter int unsigned BURST_LEN     = 128,
   parameter int unsigned LINE_BITS     = 18,
   parameter int unsigned RING_LINES    = 4096,
   parameter int unsigned LINE_SHIFT    = 9,
   parameter int unsigned FIFO_DEPTH    = 512
`ifdef MEM_VOUT_TIMEOUT_EN
   ,parameter int unsigned TIMEOUT_CYCLES = 4096
`endif
) (
   input  logic                 ddr_clk_i,
   input  logic                 ddr_rst_i,
   input  logic                 laser_start_i,
   input  logic [LINE_BITS-1:0] wr_burst_line_i,
   output logic [LINE_BITS-1:0] rd_burst_line_o,
   output logic                 overrun_o,
   output logic                 timeout_err_o,
   output logic                 ddr_fifo_empty_o,
   input  logic                 ddr_fifo_rd_en_i,
   output logic                 ddr_fifo_rd_vld_o,
   output logic [OUT_WIDTH-1:0] ddr_fifo_rd_data_o,
   output logic                 ddr_fifo_clear_o,
   mem_vout_ring_reader_if.master ddr
);
   localparam int unsigned RATIO    = MEM_DATA_BITS / OUT_WIDTH;
   localparam int unsigned SUB_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned RING_W   = $clog2(RING_LINES);
   localparam int unsigned PAD_W    = LINE_BITS - RING_W;
   localparam int unsigned PF_LEVEL = FIFO_DEPTH - BURST_LEN;

   typedef enum logic [2:0] {S_IDLE, S_START, S_REQ, S_BURST, S_GAP, S_FLUSH} state_t;

   state_t                   state;
   logic [1:0]               lsync;
   logic                     rise, fall, active, stop_now;
   logic [LINE_BITS-1:0]     rd_line, avail;
   logic                     line_empty, ovr_now, overrun, overrun_set, fall_pend, clear;
   logic [3:0]               flush_cnt;
   logic [ADDR_WIDTH-1:0]    addr_nxt;

   logic [MEM_DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]         wr_ptr, rd_ptr;
   logic [SUB_W-1:0]         sub;
   logic [CNT_W-1:0]         cnt, cnt_nxt;
   logic                     fifo_empty, fifo_full, prog_full, fifo_wr, fifo_rd, sub_last, pop_entry;
   logic [MEM_DATA_BITS-1:0] rd_entry;
   logic [OUT_WIDTH-1:0]     rd_word, rd_data;
   logic                     rd_vld;

   // Frame gate edges from the two synchroniser stages
   assign rise = lsync[0] & ~lsync[1];
   assign fall = ~lsync[0] & lsync[1];

   assign avail      = wr_burst_line_i - rd_line;
   assign line_empty = (avail == '0);
   assign ovr_now    = (avail > LINE_BITS'(RING_LINES));
   assign active     = (state == S_START) || (state == S_REQ) || (state == S_BURST) || (state == S_GAP);
   assign stop_now   = fall | fall_pend | overrun | ovr_now;
   assign addr_nxt   = ADDR_WIDTH'({1'(MEM_SEL_BIT), {PAD_W{1'b0}}, rd_line[RING_W-1:0], {LINE_SHIFT{1'b0}}});

   assign fifo_full   = (cnt == CNT_W'(FIFO_DEPTH));
   assign prog_full   = (cnt >= CNT_W'(PF_LEVEL));
   assign fifo_wr     = (state == S_BURST) && ddr.rd_ddr_data_valid && !fifo_full;
   assign fifo_rd     = ddr_fifo_rd_en_i && !fifo_empty && !clear;
   assign sub_last    = (sub == SUB_W'(RATIO - 1));
   assign pop_entry   = fifo_rd && sub_last;
   assign cnt_nxt     = cnt + CNT_W'(fifo_wr) - CNT_W'(pop_entry);
   assign overrun_set = (active && ovr_now) || ((state == S_BURST) && ddr.rd_ddr_data_valid && fifo_full);
   assign rd_entry    = mem[rd_ptr];

`ifdef MEM_VOUT_TIMEOUT_EN
   localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TCNT_W-1:0] tcnt;
   logic              timeout_err, tmo_hit;
   assign tmo_hit       = (tcnt == TCNT_W'(TIMEOUT_CYCLES - 1));
   assign timeout_err_o = timeout_err;

   // Burst watchdog: counts cycles spent in BURST, restarts on every state change
   always_ff @(posedge ddr_clk_i or posedge ddr_rst_i) begin
      if (ddr_rst_i)              tcnt <= '0;
      else if (state != S_BURST)  tcnt <= '0;
      else                        tcnt <= tcnt + TCNT_W'(1);
   end
`else
   assign timeout_err_o = 1'b0;
`endif

   // Select the current output word of the head entry
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < RATIO; i++)
         if (sub == SUB_W'(i)) rd_word = rd_entry[i*OUT_WIDTH +: OUT_WIDTH];
   end

   // Control FSM, burst request port, line counter and sticky flags
   always_ff @(posedge ddr_clk_i or posedge ddr_rst_i) begin
      if (ddr_rst_i) begin
         state           <= S_IDLE;
         lsync           <= '0;
         rd_line         <= '0;
         fall_pend       <= 1'b0;
         overrun         <= 1'b0;
         clear           <= 1'b0;
         flush_cnt       <= '0;
         ddr.rd_ddr_req  <= 1'b0;
         ddr.rd_ddr_len  <= '0;
         ddr.rd_ddr_addr <= '0;
`ifdef MEM_VOUT_TIMEOUT_EN
         timeout_err     <= 1'b0;
`endif
      end else begin
         lsync <= {lsync[0], laser_start_i};
         if ((state == S_IDLE) && rise) overrun <= 1'b0;
         else if (overrun_set)          overrun <= 1'b1;
         if (!active)   fall_pend <= 1'b0;
         else if (fall) fall_pend <= 1'b1;
         case (state)
            S_IDLE: begin
               if (rise) begin
                  state   <= S_START;
                  rd_line <= '0;
`ifdef MEM_VOUT_TIMEOUT_EN
                  timeout_err <= 1'b0;
`endif
               end
            end
            S_START: begin
               if (stop_now) begin
                  state     <= S_FLUSH;
                  clear     <= 1'b1;
                  flush_cnt <= '0;
               end else if (!line_empty) begin
                  ddr.rd_ddr_addr <= addr_nxt;
                  state           <= S_REQ;
               end
            end
            S_REQ: begin
               ddr.rd_ddr_req <= 1'b1;
               ddr.rd_ddr_len <= 8'(BURST_LEN);
               state          <= S_BURST;
            end
            S_BURST: begin
               if (ddr.rd_ddr_data_valid || ddr.rd_ddr_finish) ddr.rd_ddr_req <= 1'b0;
               if (ddr.rd_ddr_finish) begin
                  rd_line <= rd_line + LINE_BITS'(1);
                  state   <= S_GAP;
               end
`ifdef MEM_VOUT_TIMEOUT_EN
               else if (tmo_hit) begin
                  timeout_err    <= 1'b1;
                  ddr.rd_ddr_req <= 1'b0;
                  state          <= S_FLUSH;
                  clear          <= 1'b1;
                  flush_cnt      <= '0;
               end
`endif
            end
            S_GAP: begin
               if (stop_now) begin
                  state     <= S_FLUSH;
                  clear     <= 1'b1;
                  flush_cnt <= '0;
               end else if (!prog_full && !line_empty) begin
                  ddr.rd_ddr_addr <= addr_nxt;
                  state           <= S_REQ;
               end
            end
            S_FLUSH: begin
               if (flush_cnt == 4'd15) begin
                  clear <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  flush_cnt <= flush_cnt + 4'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // FIFO storage; no reset needed, validity is tracked by the pointers
   always_ff @(posedge ddr_clk_i) begin
      if (fifo_wr) mem[wr_ptr] <= ddr.rd_ddr_data;
   end

   // FIFO pointers, occupancy and registered read port; held cleared during flush
   always_ff @(posedge ddr_clk_i or posedge ddr_rst_i) begin
      if (ddr_rst_i) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         sub        <= '0;
         cnt        <= '0;
         fifo_empty <= 1'b1;
         rd_vld     <= 1'b0;
         rd_data    <= '0;
      end else if (clear) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         sub        <= '0;
         cnt        <= '0;
         fifo_empty <= 1'b1;
         rd_vld     <= 1'b0;
      end else begin
         if (fifo_wr)
            wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
         rd_vld <= fifo_rd;
         if (fifo_rd) begin
            rd_data <= rd_word;
            if (sub_last) begin
               sub    <= '0;
               rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end else begin
               sub <= sub + SUB_W'(1);
            end
         end
         cnt        <= cnt_nxt;
         fifo_empty <= (cnt_nxt == '0);
      end
   end

   assign rd_burst_line_o    = rd_line;
   assign overrun_o          = overrun;
   assign ddr_fifo_empty_o   = fifo_empty;
   assign ddr_fifo_rd_vld_o  = rd_vld;
   assign ddr_fifo_rd_data_o = rd_data;
   assign ddr_fifo_clear_o   = clear;
endmodule

// File: tb/tb_mem_vout_ring_reader.sv
// Directed bench for mem_vout_ring_reader with a small geometry; FIFO words checked via scoreboard.
module tb_mem_vout_ring_reader;
   localparam int unsigned AW  = 14;
   localparam int unsigned MDB = 64;
   localparam int unsigned OW  = 16;
   localparam int unsigned BL  = 4;
   localparam int unsigned LB  = 4;
   localparam int unsigned RL  = 4;
   localparam int unsigned LS  = 9;
   localparam int unsigned FD  = 16;
   localparam int unsigned WPB = MDB / OW;
   localparam int unsigned TMO = 64;

   logic          clk, rst, laser, rd_en;
   logic [LB-1:0] wr_line, rd_line;
   logic          overrun, tmo_err, empty, rd_vld, clear;
   logic [OW-1:0] rd_data;
   int            errors = 0;
   int            checks = 0;
   logic [OW-1:0] exp_q[$];

   mem_vout_ring_reader_if #(.ADDR_WIDTH(AW), .MEM_DATA_BITS(MDB)) ddr_bus ();

   mem_vout_ring_reader #(
      .MEM_SEL_BIT(1), .ADDR_WIDTH(AW), .MEM_DATA_BITS(MDB), .OUT_WIDTH(OW), .BURST_LEN(BL),
      .LINE_BITS(LB), .RING_LINES(RL), .LINE_SHIFT(LS), .FIFO_DEPTH(FD)
`ifdef MEM_VOUT_TIMEOUT_EN
      , .TIMEOUT_CYCLES(TMO)
`endif
   ) dut (
      .ddr_clk_i(clk), .ddr_rst_i(rst), .laser_start_i(laser),
      .wr_burst_line_i(wr_line), .rd_burst_line_o(rd_line),
      .overrun_o(overrun), .timeout_err_o(tmo_err), .ddr_fifo_empty_o(empty),
      .ddr_fifo_rd_en_i(rd_en), .ddr_fifo_rd_vld_o(rd_vld), .ddr_fifo_rd_data_o(rd_data),
      .ddr_fifo_clear_o(clear), .ddr(ddr_bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout observed=stuck required=finish");
      $fatal(1, "bench did not finish");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [AW-1:0] exp_addr(input int line);
      return AW'((1 << (LB + LS)) | ((line % RL) << LS));
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_req(output bit ok);
      int g = 0;
      while (!ddr_bus.rd_ddr_req && g < 100) begin @(negedge clk); g++; end
      ok = ddr_bus.rd_ddr_req;
   endtask

   // Act as the DDR port for one burst; optionally record its words and drop the gate mid-burst
   task automatic serve_burst(input int line, input bit push, input int fall_at);
      bit ok;
      logic [MDB-1:0] d;
      wait_req(ok);
      check("req_seen", 64'(ok), 64'(1));
      if (ok) begin
         check("req_addr", 64'(ddr_bus.rd_ddr_addr), 64'(exp_addr(line)));
         check("req_len", 64'(ddr_bus.rd_ddr_len), 64'(BL));
         for (int i = 0; i < BL; i++) begin
            d = {$urandom, $urandom};
            ddr_bus.rd_ddr_data_valid = 1'b1;
            ddr_bus.rd_ddr_data       = d;
            if (push) for (int j = 0; j < WPB; j++) exp_q.push_back(d[j*OW +: OW]);
            if (i == fall_at) laser = 1'b0;
            @(negedge clk);
            if (i == 0) check("req_drop", 64'(ddr_bus.rd_ddr_req), 64'(0));
         end
         ddr_bus.rd_ddr_data_valid = 1'b0;
         ddr_bus.rd_ddr_finish     = 1'b1;
         @(negedge clk);
         ddr_bus.rd_ddr_finish     = 1'b0;
      end
   endtask

   // Read n words from the FIFO and compare each against the scoreboard
   task automatic drain(input int n);
      int got = 0;
      int issued = 0;
      int g = 0;
      logic [OW-1:0] e;
      rd_en = 1'b0;
      while (got < n && g < 2000) begin
         @(negedge clk);
         g++;
         if (rd_vld) begin
            got++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            check("rd_data", 64'(rd_data), 64'(e));
         end
         if (issued < n && !empty) begin rd_en = 1'b1; issued++; end
         else rd_en = 1'b0;
      end
      rd_en = 1'b0;
      check("drain_count", 64'(got), 64'(n));
   endtask

   task automatic no_req(input int n, input string tag);
      logic seen = 1'b0;
      repeat (n) begin @(negedge clk); if (ddr_bus.rd_ddr_req) seen = 1'b1; end
      check(tag, 64'(seen), 64'(0));
   endtask

   task automatic flush_len(output int len);
      int g = 0;
      len = 0;
      while (!clear && g < 100) begin @(negedge clk); g++; end
      while (clear && len < 100) begin len++; @(negedge clk); end
   endtask

   initial begin
      int  n;
      bit  ok;
      rst = 1'b1; laser = 1'b0; wr_line = '0; rd_en = 1'b0;
      ddr_bus.rd_ddr_data_valid = 1'b0; ddr_bus.rd_ddr_data = '0; ddr_bus.rd_ddr_finish = 1'b0;
      tick(3);
      check("rst_req", 64'(ddr_bus.rd_ddr_req), 64'(0));
      check("rst_len", 64'(ddr_bus.rd_ddr_len), 64'(0));
      check("rst_addr", 64'(ddr_bus.rd_ddr_addr), 64'(0));
      check("rst_rd_line", 64'(rd_line), 64'(0));
      check("rst_overrun", 64'(overrun), 64'(0));
      check("rst_timeout", 64'(tmo_err), 64'(0));
      check("rst_empty", 64'(empty), 64'(1));
      check("rst_vld", 64'(rd_vld), 64'(0));
      check("rst_clear", 64'(clear), 64'(0));
      rst = 1'b0;
      tick(2);

      // Frame start, writer three lines ahead: three bursts at consecutive line addresses
      wr_line = 4'd3; laser = 1'b1;
      for (int l = 0; l < 3; l++) serve_burst(l, 1'b1, -1);
      no_req(10, "t1_stop_when_caught_up");
      check("t1_rd_line", 64'(rd_line), 64'(3));
      drain(3 * BL * WPB);
      check("t1_empty_after_drain", 64'(empty), 64'(1));

      // Writer far ahead, no reads: bursts stop at prog_full (count >= FD-BL), ring index wraps
      wr_line = 4'd7;
      for (int l = 3; l < 6; l++) serve_burst(l, 1'b1, -1);
      no_req(20, "t2_hold_at_prog_full");
      check("t2_rd_line", 64'(rd_line), 64'(6));
      drain(WPB);
      serve_burst(6, 1'b1, -1);
      check("t2_rd_line_after_resume", 64'(rd_line), 64'(7));
      drain((3 * BL - 1 + BL) * WPB);
      check("t2_sb_empty", 64'(exp_q.size()), 64'(0));

      // Writer laps the ring: overrun, 16-cycle flush, back to idle
      wr_line = 4'd12;
      flush_len(n);
      check("t3_clear_len", 64'(n), 64'(16));
      check("t3_overrun", 64'(overrun), 64'(1));
      check("t3_empty", 64'(empty), 64'(1));
      no_req(20, "t3_idle_no_req");
      check("t3_overrun_sticky", 64'(overrun), 64'(1));

      // New frame clears overrun; gate drops mid-burst: burst completes, then flush
      laser = 1'b0; tick(5);
      wr_line = 4'd2; laser = 1'b1;
      tick(4);
      check("t4_overrun_cleared", 64'(overrun), 64'(0));
      serve_burst(0, 1'b0, 1);
      check("t4_rd_line", 64'(rd_line), 64'(1));
      flush_len(n);
      check("t4_clear_len", 64'(n), 64'(16));
      no_req(30, "t4_no_req_after_fall");
      check("t4_empty", 64'(empty), 64'(1));

      // Asynchronous reset mid-burst drops the request and empties the FIFO at once
      laser = 1'b0; tick(5);
      wr_line = 4'd1; laser = 1'b1;
      wait_req(ok);
      check("t5_req_seen", 64'(ok), 64'(1));
      ddr_bus.rd_ddr_data_valid = 1'b1; ddr_bus.rd_ddr_data = {$urandom, $urandom};
      @(negedge clk);
      ddr_bus.rd_ddr_data_valid = 1'b0;
      check("t5_fifo_filled", 64'(empty), 64'(0));
      rst = 1'b1; laser = 1'b0;
      #1;
      check("t5_rst_empty", 64'(empty), 64'(1));
      check("t5_rst_rd_line", 64'(rd_line), 64'(0));
      @(negedge clk);
      check("t5_rst_req", 64'(ddr_bus.rd_ddr_req), 64'(0));
      rst = 1'b0;
      tick(3);

`ifdef MEM_VOUT_TIMEOUT_EN
      // Unanswered burst trips the watchdog after TMO cycles
      wr_line = 4'd1; laser = 1'b1;
      wait_req(ok);
      check("t6_req_seen", 64'(ok), 64'(1));
      n = 0;
      while (!tmo_err && n < 200) begin @(negedge clk); n++; end
      check("t6_tmo_cycles", 64'(n), 64'(TMO));
      check("t6_req_drop", 64'(ddr_bus.rd_ddr_req), 64'(0));
      flush_len(n);
      check("t6_clear_len", 64'(n), 64'(16));
      check("t6_tmo_sticky", 64'(tmo_err), 64'(1));
      laser = 1'b0; tick(4); laser = 1'b1; tick(4);
      check("t6_tmo_cleared", 64'(tmo_err), 64'(0));
`else
      check("timeout_tied_low", 64'(tmo_err), 64'(0));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
